// File: rtl/hub75_frame_fetch.sv
// HUB75 frame buffer and bit-plane pixel sequencer.
// Holds a COLS x 2*ROWS image split into top/bottom banks. Streams one bit-plane
// of one scan-row pair per request. Row/plane advance is paced by row_done.
module hub75_frame_fetch #(
   parameter int COLS  = 64,
   parameter int ROWS  = 16,
   parameter int CBITS = 4,
   parameter int COL_W = 6,
   parameter int ROW_W = 4,
   parameter int PL_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [COL_W-1:0]     wr_x,
   input  logic [ROW_W:0]       wr_y,
   input  logic [3*CBITS-1:0]   wr_rgb,
   output logic                 px_valid,
   input  logic                 px_ready,
   output logic [2:0]           px_rgb0,
   output logic [2:0]           px_rgb1,
   output logic [COL_W-1:0]     px_col,
   output logic                 px_last,
   output logic [ROW_W-1:0]     row_addr,
   output logic [PL_W-1:0]      plane,
   input  logic                 row_done,
   output logic                 frame_start
);

   localparam int AW    = ROW_W + COL_W;
   localparam int DEPTH = COLS * ROWS;
   localparam int WW    = 3 * CBITS;
   localparam int IW    = $clog2(WW);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_WAIT_DONE
   } state_t;

   // Frame storage, one bank per panel half
   logic [WW-1:0]     r_mem_top [DEPTH];
   logic [WW-1:0]     r_mem_bot [DEPTH];

   // Sequencer state
   state_t            r_state;
   logic [ROW_W-1:0]  r_row;
   logic [PL_W-1:0]   r_plane;
   logic              r_frame_start;

   // Read issue (prefetch) stage
   logic [COL_W-1:0]  r_iss_col;
   logic              r_iss_done;
   logic              r_rd_vld;
   logic [COL_W-1:0]  r_rd_col;
   logic [WW-1:0]     r_rd_top;
   logic [WW-1:0]     r_rd_bot;

   // Output register and skid entry
   logic              r_out_v;
   logic [2:0]        r_out_rgb0;
   logic [2:0]        r_out_rgb1;
   logic [COL_W-1:0]  r_out_col;
   logic              r_out_last;
   logic              r_skid_v;
   logic [2:0]        r_skid_rgb0;
   logic [2:0]        r_skid_rgb1;
   logic [COL_W-1:0]  r_skid_col;
   logic              r_skid_last;

   logic [AW-1:0]     w_wr_addr;
   logic [AW-1:0]     w_rd_addr;
   logic              w_pop;
   logic [1:0]        w_fill;
   logic              w_issue;
   logic [IW-1:0]     w_ir;
   logic [IW-1:0]     w_ig;
   logic [IW-1:0]     w_ib;
   logic [2:0]        w_in_rgb0;
   logic [2:0]        w_in_rgb1;
   logic              w_in_last;
   logic [ROW_W-1:0]  w_nxt_row;
   logic [PL_W-1:0]   w_nxt_plane;

   assign w_wr_addr = {wr_y[ROW_W-1:0], wr_x};
   assign w_rd_addr = {r_row, r_iss_col};
   assign w_pop     = r_out_v & px_ready;

   // Issue a read only if the word it returns is guaranteed a slot next cycle:
   // entries held after this edge plus the one already in flight must be < 2.
   assign w_fill  = 2'(r_out_v) + 2'(r_skid_v) + 2'(r_rd_vld) - 2'(w_pop);
   assign w_issue = (r_state == S_STREAM) && !r_iss_done && (w_fill < 2'd2);

   // Select the current plane bit of each colour from the returned words
   always_comb begin
      w_ib         = IW'(r_plane);
      w_ig         = IW'(CBITS) + IW'(r_plane);
      w_ir         = IW'(2 * CBITS) + IW'(r_plane);
      w_in_rgb0    = {r_rd_top[w_ib], r_rd_top[w_ig], r_rd_top[w_ir]};
      w_in_rgb1    = {r_rd_bot[w_ib], r_rd_bot[w_ig], r_rd_bot[w_ir]};
      w_in_last    = (r_rd_col == COL_W'(COLS - 1));
   end

   // Next (row, plane) position: plane fastest, row wraps after the last plane
   always_comb begin
      w_nxt_row   = r_row;
      w_nxt_plane = r_plane + PL_W'(1);
      if (r_plane == PL_W'(CBITS - 1)) begin
         w_nxt_plane = '0;
         w_nxt_row   = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);
      end
   end

   // Host write port; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_en && !wr_y[ROW_W]) r_mem_top[w_wr_addr] <= wr_rgb;
      if (wr_en &&  wr_y[ROW_W]) r_mem_bot[w_wr_addr] <= wr_rgb;
   end

   // Read port: both banks at the same address, one-cycle latency, read-before-write
   always_ff @(posedge clk) begin
      if (w_issue) begin
         r_rd_top <= r_mem_top[w_rd_addr];
         r_rd_bot <= r_mem_bot[w_rd_addr];
      end
   end

   // Sequencer FSM, prefetch counter and output/skid buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_row         <= '0;
         r_plane       <= '0;
         r_frame_start <= 1'b0;
         r_iss_col     <= '0;
         r_iss_done    <= 1'b0;
         r_rd_vld      <= 1'b0;
         r_rd_col      <= '0;
         r_out_v       <= 1'b0;
         r_out_rgb0    <= '0;
         r_out_rgb1    <= '0;
         r_out_col     <= '0;
         r_out_last    <= 1'b0;
         r_skid_v      <= 1'b0;
         r_skid_rgb0   <= '0;
         r_skid_rgb1   <= '0;
         r_skid_col    <= '0;
         r_skid_last   <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;

         r_rd_vld <= w_issue;
         if (w_issue) begin
            r_rd_col <= r_iss_col;
            if (r_iss_col == COL_W'(COLS - 1)) r_iss_done <= 1'b1;
            else                               r_iss_col  <= r_iss_col + COL_W'(1);
         end

         // Skid only ever holds data while the output register is also full,
         // so on a pop it refills the output ahead of the arriving read.
         if (w_pop) begin
            if (r_skid_v) begin
               r_out_rgb0 <= r_skid_rgb0;
               r_out_rgb1 <= r_skid_rgb1;
               r_out_col  <= r_skid_col;
               r_out_last <= r_skid_last;
               r_skid_v   <= r_rd_vld;
               if (r_rd_vld) begin
                  r_skid_rgb0 <= w_in_rgb0;
                  r_skid_rgb1 <= w_in_rgb1;
                  r_skid_col  <= r_rd_col;
                  r_skid_last <= w_in_last;
               end
            end else if (r_rd_vld) begin
               r_out_rgb0 <= w_in_rgb0;
               r_out_rgb1 <= w_in_rgb1;
               r_out_col  <= r_rd_col;
               r_out_last <= w_in_last;
            end else begin
               r_out_v    <= 1'b0;
               r_out_last <= 1'b0;
            end
         end else if (r_rd_vld) begin
            if (!r_out_v) begin
               r_out_v    <= 1'b1;
               r_out_rgb0 <= w_in_rgb0;
               r_out_rgb1 <= w_in_rgb1;
               r_out_col  <= r_rd_col;
               r_out_last <= w_in_last;
            end else begin
               r_skid_v    <= 1'b1;
               r_skid_rgb0 <= w_in_rgb0;
               r_skid_rgb1 <= w_in_rgb1;
               r_skid_col  <= r_rd_col;
               r_skid_last <= w_in_last;
            end
         end

         case (r_state)
            S_IDLE: begin
               r_state       <= S_STREAM;
               r_iss_col     <= '0;
               r_iss_done    <= 1'b0;
               r_frame_start <= (r_row == '0) && (r_plane == '0);
            end
            S_STREAM: begin
               if (w_pop && r_out_last) r_state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (row_done) begin
                  r_state       <= S_STREAM;
                  r_row         <= w_nxt_row;
                  r_plane       <= w_nxt_plane;
                  r_iss_col     <= '0;
                  r_iss_done    <= 1'b0;
                  r_frame_start <= (w_nxt_row == '0) && (w_nxt_plane == '0);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign px_valid    = r_out_v;
   assign px_rgb0     = r_out_rgb0;
   assign px_rgb1     = r_out_rgb1;
   assign px_col      = r_out_col;
   assign px_last     = r_out_last;
   assign row_addr    = r_row;
   assign plane       = r_plane;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_hub75_frame_fetch.sv
// Directed testbench for hub75_frame_fetch.
module tb_hub75_frame_fetch;

   localparam int COLS  = 64;
   localparam int ROWS  = 16;
   localparam int CBITS = 4;
   localparam int COL_W = 6;
   localparam int ROW_W = 4;
   localparam int PL_W  = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               wr_en = 1'b0;
   logic [COL_W-1:0]   wr_x = '0;
   logic [ROW_W:0]     wr_y = '0;
   logic [3*CBITS-1:0] wr_rgb = '0;
   logic               px_valid;
   logic               px_ready = 1'b1;
   logic [2:0]         px_rgb0;
   logic [2:0]         px_rgb1;
   logic [COL_W-1:0]   px_col;
   logic               px_last;
   logic [ROW_W-1:0]   row_addr;
   logic [PL_W-1:0]    plane;
   logic               row_done = 1'b0;
   logic               frame_start;

   always #5 clk = ~clk;

   hub75_frame_fetch #(
      .COLS(COLS), .ROWS(ROWS), .CBITS(CBITS),
      .COL_W(COL_W), .ROW_W(ROW_W), .PL_W(PL_W)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
      .px_valid(px_valid), .px_ready(px_ready),
      .px_rgb0(px_rgb0), .px_rgb1(px_rgb1), .px_col(px_col), .px_last(px_last),
      .row_addr(row_addr), .plane(plane),
      .row_done(row_done), .frame_start(frame_start)
   );

   int n_cmp = 0;
   int n_err = 0;
   int fs_cnt = 0;
   int fs_bad = 0;

   logic [11:0] m_top [1024];
   logic [11:0] m_bot [1024];
   logic [2:0]  cap0 [64];
   logic [2:0]  cap1 [64];
   logic        caplast [64];

   // frame_start must only ever appear at row 0 plane 0, before any pixel
   always @(negedge clk) begin
      if (!rst && frame_start) begin
         fs_cnt++;
         if (row_addr != 0 || plane != 0 || px_valid) fs_bad++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] ext(input logic [11:0] w, input int p);
      logic [2:0] e;
      e[0] = w[8+p];
      e[1] = w[4+p];
      e[2] = w[p];
      return e;
   endfunction

   task automatic pulse_rd();
      row_done = 1'b1;
      @(negedge clk);
      row_done = 1'b0;
   endtask

   // Consume one full row; mode 0 = always ready, 1 = random ready
   task automatic do_row(input int mode, input int erow, input int epl,
                         input bit chkdata, input bit extra);
      int waitc, n, iters, stall_bad, order_bad, data_bad;
      bit stalled;
      logic [2:0] h0, h1;
      logic [COL_W-1:0] hc;
      logic hl;
      waitc = 0;
      while (!px_valid && waitc < 8) begin
         @(negedge clk);
         waitc++;
      end
      chk("first_valid_latency", 32'(waitc <= 2), 32'd1);
      chk("row_addr", 32'(row_addr), 32'(erow));
      chk("plane", 32'(plane), 32'(epl));
      n = 0; iters = 0; stall_bad = 0; order_bad = 0; data_bad = 0; stalled = 1'b0;
      h0 = '0; h1 = '0; hc = '0; hl = 1'b0;
      while (n < 64 && iters < 1000) begin
         if (stalled && (px_valid !== 1'b1 || px_rgb0 !== h0 || px_rgb1 !== h1 ||
                         px_col !== hc || px_last !== hl)) stall_bad++;
         px_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (extra) row_done = 1'($urandom_range(0, 1));
         if (px_valid && px_ready) begin
            if (px_col !== 6'(n)) order_bad++;
            cap0[n] = px_rgb0;
            cap1[n] = px_rgb1;
            caplast[n] = px_last;
            n++;
            stalled = 1'b0;
         end else if (px_valid) begin
            stalled = 1'b1;
            h0 = px_rgb0; h1 = px_rgb1; hc = px_col; hl = px_last;
         end else begin
            stalled = 1'b0;
         end
         @(negedge clk);
         iters++;
      end
      row_done = 1'b0;
      chk("transfers", 32'(n), 32'd64);
      chk("col_order", 32'(order_bad), 32'd0);
      chk("stall_hold", 32'(stall_bad), 32'd0);
      if (mode == 0) chk("row_cycles", 32'(iters), 32'd64);
      chk("wait_no_valid", 32'(px_valid), 32'd0);
      if (chkdata) begin
         for (int c = 0; c < 64; c++) begin
            if (cap0[c] !== ext(m_top[erow*64+c], epl)) data_bad++;
            if (cap1[c] !== ext(m_bot[erow*64+c], epl)) data_bad++;
            if (caplast[c] !== (c == 63)) data_bad++;
         end
         chk("row_data", 32'(data_bad), 32'd0);
      end
   endtask

   initial begin
      logic [3:0] r_a00;
      int r, p, cnt;
      r_a00 = 4'b1010;

      // 1: reset and first row
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_outputs", 32'({px_valid, px_rgb0, px_rgb1, px_col, px_last,
                                   row_addr, plane, frame_start}), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("fs_first", 32'(frame_start), 32'd1);
      chk("valid_after_release", 32'(px_valid), 32'd0);
      @(negedge clk);
      chk("fs_one_cycle", 32'(frame_start), 32'd0);
      do_row(0, 0, 0, 1'b0, 1'b0);

      // Clear memory and load the test pattern while parked in WAIT_DONE
      for (int i = 0; i < 2048; i++) begin
         wr_en = 1'b1;
         wr_x = 6'(i);
         wr_y = 5'(i >> 6);
         wr_rgb = 12'h000;
         if (i < 1024) m_top[i] = 12'h000;
         else          m_bot[i-1024] = 12'h000;
         @(negedge clk);
      end
      wr_x = 6'd5;  wr_y = 5'd3;  wr_rgb = 12'hA00; m_top[3*64+5]  = 12'hA00; @(negedge clk);
      wr_x = 6'd63; wr_y = 5'd19; wr_rgb = 12'h00F; m_bot[3*64+63] = 12'h00F; @(negedge clk);
      wr_x = 6'd10; wr_y = 5'd0;  wr_rgb = 12'hFFF; m_top[0*64+10] = 12'hFFF; @(negedge clk);
      wr_en = 1'b0;
      chk("wait_hold", 32'({px_valid, row_addr, plane}), 32'd0);

      // 2-5: walk the frame up to (15,3)
      for (int k = 1; k < 64; k++) begin
         pulse_rd();
         r = k / 4;
         p = k % 4;
         do_row((k % 3 == 1) ? 1 : 0, r, p, 1'b1, 1'(k % 2));
         if (k >= 12 && k <= 15) begin
            chk("t2_col5_R", 32'(cap0[5][0]), 32'(r_a00[p]));
            chk("t2_col5_low", 32'(cap1[5]), 32'd0);
            chk("t2_col4", 32'(cap0[4]), 32'd0);
            chk("t3_col63_rgb1", 32'(cap1[63]), 32'b100);
            chk("t3_col63_last", 32'(caplast[63]), 32'd1);
            chk("t3_col63_rgb0", 32'(cap0[63]), 32'd0);
         end
      end

      // Wrap to (0,0), then reset mid-row
      pulse_rd();
      cnt = 0;
      while (!px_valid && cnt < 8) begin
         @(negedge clk);
         cnt++;
      end
      chk("wrap_row", 32'({row_addr, plane}), 32'd0);
      chk("fs_count_wrap", 32'(fs_cnt), 32'd2);
      px_ready = 1'b1;
      cnt = 0;
      while (px_col != 6'd30 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      chk("reached_col30", 32'(px_col), 32'd30);
      rst = 1'b1;
      @(negedge clk);
      chk("valid_after_rst", 32'(px_valid), 32'd0);
      chk("reset_mid_row", 32'({px_valid, px_rgb0, px_rgb1, px_col, px_last,
                                row_addr, plane, frame_start}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("fs_after_rst", 32'(frame_start), 32'd1);
      @(negedge clk);
      do_row(0, 0, 0, 1'b1, 1'b0);
      chk("t6_col10", 32'(cap0[10]), 32'b111);
      chk("fs_count_final", 32'(fs_cnt), 32'd3);
      chk("fs_position", 32'(fs_bad), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
